// File: rtl/sig_edge_det_if.sv
// Channel bundle for sig_edge_det: raw levels in, detected level and
// rise/fall/any pulses out.
interface sig_edge_det_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] in;
    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] any;

    modport master (
        output in,
        input  level,
        input  rise,
        input  fall,
        input  any
    );

    modport slave (
        input  in,
        output level,
        output rise,
        output fall,
        output any
    );
endinterface

// File: rtl/sig_edge_det.sv
// Multi-channel edge detector with optional sync chain; define
// SIG_EDGE_DET_GLITCH_FILTER_EN to build the per-channel glitch filter.
module sig_edge_det #(
    parameter int WIDTH       = 1,
    parameter int SYNC_STAGES = 0,
    parameter bit RESET_LEVEL = 1'b0,
    parameter int FILTER_LEN  = 4
) (
    input logic     clk,
    input logic     rst,
    sig_edge_det_if.slave bus
);
    localparam logic [WIDTH-1:0] RST_VEC = {WIDTH{RESET_LEVEL}};

    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] rise_raw;
    logic [WIDTH-1:0] fall_raw;
    logic [WIDTH-1:0] lvl;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s = bus.in;
        end else begin : g_sync
            logic [WIDTH-1:0] sync_q [SYNC_STAGES];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < SYNC_STAGES; i++) begin
                        sync_q[i] <= RST_VEC;
                    end
                end else begin
                    sync_q[0] <= bus.in;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end

            assign s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

`ifdef SIG_EDGE_DET_GLITCH_FILTER_EN
    localparam int CW = $clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

    logic [WIDTH-1:0] flt;
    logic [WIDTH-1:0] flt_nxt;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] fall_q;
    logic [CW-1:0]    cnt [WIDTH];

    // A channel's filtered level follows s only after FILTER_LEN
    // consecutive disagreeing samples.
    always_comb begin
        flt_nxt = flt;
        for (int i = 0; i < WIDTH; i++) begin
            if (s[i] != flt[i] && cnt[i] == CNT_LAST) begin
                flt_nxt[i] = s[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flt    <= RST_VEC;
            rise_q <= '0;
            fall_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            flt    <= flt_nxt;
            rise_q <= flt_nxt & ~flt;
            fall_q <= ~flt_nxt & flt;
            for (int i = 0; i < WIDTH; i++) begin
                if (s[i] == flt[i] || cnt[i] == CNT_LAST) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign rise_raw = rise_q;
    assign fall_raw = fall_q;
    assign lvl      = flt;
`else
    logic [WIDTH-1:0] prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= RST_VEC;
        end else begin
            prev <= s;
        end
    end

    assign rise_raw = s & ~prev;
    assign fall_raw = ~s & prev;
    assign lvl      = s;
`endif

    // Pulses are held off for the whole reset window; level is not.
    assign bus.rise  = rise_raw & ~{WIDTH{rst}};
    assign bus.fall  = fall_raw & ~{WIDTH{rst}};
    assign bus.any   = bus.rise | bus.fall;
    assign bus.level = lvl;

endmodule

// File: tb/tb_sig_edge_det.sv
// Self-checking bench for sig_edge_det: vector table, hand sequences and
// a randomized run against a history-based reference model.
module tb_sig_edge_det;
    localparam int FL  = 4;
    localparam int N1  = 2;
    localparam int PRE = 8;
    localparam int NR  = 400;
    localparam logic [3:0] RL1 = 4'b0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    sig_edge_det_if #(.WIDTH(1)) b0 ();
    sig_edge_det_if #(.WIDTH(4)) b1 ();
    sig_edge_det_if #(.WIDTH(2)) b2 ();

    sig_edge_det #(
        .WIDTH(1), .SYNC_STAGES(0), .RESET_LEVEL(1'b0), .FILTER_LEN(FL)
    ) u0 (.clk(clk), .rst(rst), .bus(b0));

    sig_edge_det #(
        .WIDTH(4), .SYNC_STAGES(N1), .RESET_LEVEL(1'b0), .FILTER_LEN(FL)
    ) u1 (.clk(clk), .rst(rst), .bus(b1));

    sig_edge_det #(
        .WIDTH(2), .SYNC_STAGES(0), .RESET_LEVEL(1'b1), .FILTER_LEN(FL)
    ) u2 (.clk(clk), .rst(rst), .bus(b2));

    typedef struct {
        logic r;
        logic i;
        logic ri;
        logic f;
        logic a;
        logic l;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic [5:0] v);
        vec_t e;
        e.r  = v[5];
        e.i  = v[4];
        e.ri = v[3];
        e.f  = v[2];
        e.a  = v[1];
        e.l  = v[0];
        tbl.push_back(e);
    endfunction

    task automatic chk(input string name, input logic [3:0] act,
                       input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got %b want %b", name, $time, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Reference model state, one entry per random-phase cycle.
    logic [3:0] in_h  [NR+PRE];
    bit         rst_h [NR+PRE];
    logic [3:0] s_h   [NR+PRE];
    logic [3:0] flt_h [NR+PRE];

    task automatic model(input int t, output logic [3:0] lv,
                         output logic [3:0] ri, output logic [3:0] fa);
        bit rr;
        logic [3:0] prev;
        rr = 1'b0;
        for (int c = t - N1; c < t; c++) if (rst_h[c]) rr = 1'b1;
        s_h[t] = rr ? RL1 : in_h[t-N1];
        if (rst_h[t-1]) begin
            flt_h[t] = RL1;
        end else begin
            for (int b = 0; b < 4; b++) begin
                bit ok;
                ok = 1'b1;
                for (int c = t - FL; c < t; c++) begin
                    if (s_h[c][b] == flt_h[c][b]) ok = 1'b0;
                    if (flt_h[c][b] != flt_h[t-1][b]) ok = 1'b0;
                end
                for (int c = t - FL; c < t - 1; c++) if (rst_h[c]) ok = 1'b0;
                flt_h[t][b] = ok ? s_h[t-1][b] : flt_h[t-1][b];
            end
        end
`ifdef SIG_EDGE_DET_GLITCH_FILTER_EN
        lv = flt_h[t];
        if (rst_h[t] || rst_h[t-1]) begin
            ri = '0;
            fa = '0;
        end else begin
            ri = flt_h[t] & ~flt_h[t-1];
            fa = ~flt_h[t] & flt_h[t-1];
        end
`else
        prev = rst_h[t-1] ? RL1 : s_h[t-1];
        lv = s_h[t];
        if (rst_h[t]) begin
            ri = '0;
            fa = '0;
        end else begin
            ri = s_h[t] & ~prev;
            fa = ~s_h[t] & prev;
        end
`endif
    endtask

    initial begin
        logic [3:0] mlv, mri, mfa, cur;
        logic st, sp;
        logic [1:0] u2seq [9];
        logic [1:0] u2exp [9];

        b0.in = 1'b0;
        b1.in = 4'b0000;
        b2.in = 2'b11;
        rst   = 1'b1;
        next_cycle();

`ifndef SIG_EDGE_DET_GLITCH_FILTER_EN
        add(6'b100000);
        add(6'b100000);
        for (int k = 0; k < 5; k++) add(6'b000000);
        add(6'b011011);
        for (int k = 0; k < 4; k++) add(6'b010001);
        add(6'b000110);
        add(6'b000000);
        for (int k = 0; k < 4; k++) begin
            add(6'b011011);
            add(6'b000110);
        end
        add(6'b110001);
        add(6'b100000);
        add(6'b110001);
        add(6'b011011);
        add(6'b010001);
        add(6'b000110);

        foreach (tbl[n]) begin
            rst   = tbl[n].r;
            b0.in = tbl[n].i;
            @(negedge clk);
            chk("tbl.rise",  4'(b0.rise),  4'(tbl[n].ri));
            chk("tbl.fall",  4'(b0.fall),  4'(tbl[n].f));
            chk("tbl.any",   4'(b0.any),   4'(tbl[n].a));
            chk("tbl.level", 4'(b0.level), 4'(tbl[n].l));
            next_cycle();
        end

        rst = 1'b0;
        b1.in = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("w4.idle.rise", b1.rise, 4'b0000);
            next_cycle();
        end
        b1.in = 4'b1010;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("w4.up.rise", b1.rise, (k == 2) ? 4'b1010 : 4'b0000);
            chk("w4.up.fall", b1.fall, 4'b0000);
            chk("w4.up.level", b1.level, (k >= 2) ? 4'b1010 : 4'b0000);
            next_cycle();
        end
        b1.in = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("w4.dn.fall", b1.fall, (k == 2) ? 4'b1010 : 4'b0000);
            chk("w4.dn.rise", b1.rise, 4'b0000);
            next_cycle();
        end

        // {scl,sda} inputs and expected {start,stop}
        u2seq = '{2'b11, 2'b10, 2'b10, 2'b11, 2'b11,
                  2'b01, 2'b00, 2'b01, 2'b11};
        u2exp = '{2'b00, 2'b10, 2'b00, 2'b01, 2'b00,
                  2'b00, 2'b00, 2'b00, 2'b00};
        for (int k = 0; k < 9; k++) begin
            b2.in = u2seq[k];
            @(negedge clk);
            st = b2.any[0] & ~b2.level[0] & b2.level[1];
            sp = b2.any[0] & b2.level[0] & b2.level[1];
            chk("i2c.start", 4'(st), 4'(u2exp[k][1]));
            chk("i2c.stop",  4'(sp), 4'(u2exp[k][0]));
            chk("i2c.level", 4'(b2.level), 4'(u2seq[k]));
            next_cycle();
        end
`else
        rst = 1'b1;
        b0.in = 1'b0;
        next_cycle();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) next_cycle();
        for (int k = 0; k < 12; k++) begin
            b0.in = (k < 3);
            @(negedge clk);
            chk("flt.short.rise",  4'(b0.rise),  4'b0);
            chk("flt.short.fall",  4'(b0.fall),  4'b0);
            chk("flt.short.level", 4'(b0.level), 4'b0);
            next_cycle();
        end
        for (int k = 0; k < 16; k++) begin
            b0.in = (k < 6);
            @(negedge clk);
            chk("flt.long.rise",  4'(b0.rise),  4'(k == 4));
            chk("flt.long.fall",  4'(b0.fall),  4'(k == 10));
            chk("flt.long.level", 4'(b0.level), 4'(k >= 4 && k < 10));
            next_cycle();
        end
`endif

        for (int t = 0; t < PRE; t++) begin
            in_h[t]  = '0;
            rst_h[t] = 1'b1;
            s_h[t]   = RL1;
            flt_h[t] = RL1;
        end
        cur = 4'b0000;
        for (int t = PRE; t < NR + PRE; t++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 4) == 0) cur[b] = ~cur[b];
            end
            if (t > PRE + 200 && t < PRE + 240) cur = $urandom_range(0, 15);
            rst = (t < PRE + 3) || ($urandom_range(0, 49) == 0);
            b1.in = cur;
            in_h[t]  = cur;
            rst_h[t] = rst;
            model(t, mlv, mri, mfa);
            @(negedge clk);
            if (t >= PRE + 3) begin
                chk("rnd.level", b1.level, mlv);
                chk("rnd.rise",  b1.rise,  mri);
                chk("rnd.fall",  b1.fall,  mfa);
                chk("rnd.any",   b1.any,   mri | mfa);
            end
            next_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sig_edge_det.md
Name: sig_edge_det

Overview:
- Multi-channel edge detector that turns level changes on sampled inputs into single-cycle pulses: rising, falling and any-edge.
- Generalises the single-bit positive-edge and dual-edge detectors used by the I2C slave for START/STOP detection, SCL falling-edge detection and toggle-to-pulse handshakes (write_req).
- Sits between raw or synchronised input pins/toggle signals and the control FSMs that consume the pulses.

Parameters:
- WIDTH, 1, number of independent channels.
- SYNC_STAGES, 0, number of flip-flop stages inserted before detection (0–3). Use 0 for inputs that are already synchronous; use 2 or more for asynchronous pins such as scl/sda.
- RESET_LEVEL, 0, value loaded into every channel's history and sync registers on reset. All bits use the same value.
- FILTER_LEN, 4, stable-cycle count required when the glitch filter is built in (range 1–255). Ignored otherwise.

Ports:
- clk  input  1  system clock; all registers update on its rising edge.
- rst  input  1  synchronous reset, active-high.
- in  input  WIDTH  raw channel levels.
- level  output  WIDTH  current detected level per channel (sync output, or filtered level).
- rise  output  WIDTH  one-cycle pulse on a 0->1 transition.
- fall  output  WIDTH  one-cycle pulse on a 1->0 transition.
- any  output  WIDTH  one-cycle pulse on either transition; equals rise | fall.

Behaviour:
- Per channel, s = in delayed by SYNC_STAGES flops (s = in when SYNC_STAGES = 0). prev is a register capturing s every cycle.
- Unfiltered build (combinational outputs from the current sample):
  - rise = s & ~prev
  - fall = ~s & prev
  - any = s ^ prev
  - level = s
- Latency with SYNC_STAGES = 0: a pulse appears in the same cycle the new value is present on in, while level already shows the new value. Consumers may therefore combine any with level to get direction, e.g. "any & ~level & other_signal" detects a falling edge.
- Latency with SYNC_STAGES = N: the pulse appears N cycles after the change on in.
- Each pulse lasts exactly one cycle per transition, including when the input toggles every cycle; any is then high every cycle.
- Channels are fully independent. Simultaneous edges on several channels each produce their own pulse.
- Reset (rst = 1 at a clk edge): prev and all sync flops load RESET_LEVEL. While rst is high, rise, fall and any are forced to 0. level still reflects s.
- First cycle after reset: if s differs from RESET_LEVEL, the corresponding pulse fires once. For example, RESET_LEVEL = 0 and in held at 1 gives one rise pulse.
- Reset mid-pulse: the pulse is suppressed, and history is reloaded with RESET_LEVEL.
- No X propagation: every register has a defined reset value.

Optional Feature:
- Macro: SIG_EDGE_DET_GLITCH_FILTER_EN.
- When defined:
  - Each channel gets a filtered level register flt (reset to RESET_LEVEL) and a counter of width clog2(FILTER_LEN + 1) (reset to 0).
  - When s != flt, the counter increments. When s == flt, the counter clears.
  - When the counter reaches FILTER_LEN - 1 while s != flt, flt takes s and the counter clears. A pulse shorter than FILTER_LEN cycles is therefore ignored.
  - Edges are computed from flt against its own previous value, are registered, and last one cycle.
  - Added latency is FILTER_LEN cycles from s.
  - level = flt.
- When undefined: no filter logic is generated and the combinational path described above applies.

Test Plan:
- WIDTH = 1, SYNC_STAGES = 0, RESET_LEVEL = 0. Release rst with in = 0, then drive in 0->1 at cycle 5 and 1->0 at cycle 10. Required: rise = 1 only in cycle 5, fall = 1 only in cycle 10, any = 1 in both cycles, level = in every cycle.
- Toggle in every cycle for 8 cycles. Required: any = 1 for all 8 cycles, with rise and fall alternating.
- Assert rst for 3 cycles while in toggles. Required: rise = fall = any = 0 throughout reset. With RESET_LEVEL = 0 and in = 1 at release, exactly one rise pulse in the first post-reset cycle.
- WIDTH = 4, SYNC_STAGES = 2. Drive in 0000 -> 1010. Required: rise = 1010 exactly 2 cycles later for one cycle; fall = 0000.
- START-style check, WIDTH = 2 with channel 0 = sda, channel 1 = scl. With scl = 1, drop sda 1->0. Required: any[0] & ~level[0] & level[1] = 1 for exactly one cycle. Raising sda with scl = 1 gives any[0] & level[0] & level[1] = 1 for one cycle (STOP).
- With SIG_EDGE_DET_GLITCH_FILTER_EN defined and FILTER_LEN = 4: a 3-cycle high pulse on in produces no rise. A 6-cycle high pulse produces one rise 4 cycles after s rises, then one fall 4 cycles after s falls.
